hazard_ctrl_unit: RTL and testbench



---
 rtl/hazard_ctrl_unit.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Per-core pipeline hazard controller: drives latch enable/flush vectors from
// memory wait, halt, mispredict, load-use, jump and I-fetch miss events.
module hazard_ctrl_unit #(
    parameter int NLATCH     = 4,
    parameter int BR_LATCH   = 2,
    parameter int LU_BUBBLES = 1,
    parameter int CW         = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dreq,
    input  logic              dhit,
    input  logic              halt,
    input  logic              mispredict,
    input  logic              jumping,
    input  logic              load_use,
    output logic [NLATCH-1:0] en,
    output logic [NLATCH-1:0] flush,
    output logic              halted,
    output logic [CW-1:0]     stall_cnt,
    output logic [CW-1:0]     flush_cnt,
    output logic [1:0]        dbg_state,
    output logic [2:0]        dbg_lu_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        LUSTALL = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam logic [NLATCH-1:0] ALL_ONES   = '1;
    localparam logic [NLATCH-1:0] HALT_FLUSH = ALL_ONES >> 1;
    localparam logic [NLATCH-1:0] BR_FLUSH   = ALL_ONES >> (NLATCH - BR_LATCH);
    localparam logic [NLATCH-1:0] FD_HOLD_EN = ALL_ONES << 1;
    localparam logic [NLATCH-1:0] FD_BUBBLE  = {{(NLATCH-1){1'b0}}, 1'b1};
    localparam logic [NLATCH-1:0] DE_BUBBLE  = {{(NLATCH-2){1'b0}}, 2'b10};
    localparam logic [2:0]        LU_INIT    = 3'(LU_BUBBLES - 1);
    localparam logic [CW-1:0]     CNT_MAX    = '1;

    state_t      state, state_nxt;
    logic [2:0]  lu_cnt, lu_nxt;
    logic        squash;
    logic        stall_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= RUN;
            lu_cnt <= 3'd0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_nxt;
        end
    end

    // RUN and LUSTALL share one priority chain; memory wait always wins because
    // the stage that raised halt/mispredict is frozen until dhit.
    always_comb begin
        state_nxt = state;
        lu_nxt    = lu_cnt;
        en        = ALL_ONES;
        flush     = '0;
        squash    = 1'b0;
        case (state)
            RUN, LUSTALL: begin
                if (dreq && !dhit) begin
                    en        = '0;
                    state_nxt = MEMWAIT;
                end else if (halt) begin
                    flush     = HALT_FLUSH;
                    state_nxt = HALTED;
                end else if (mispredict) begin
                    flush     = BR_FLUSH;
                    squash    = 1'b1;
                    lu_nxt    = 3'd0;
                    state_nxt = RUN;
                end else if (load_use || state == LUSTALL) begin
                    en    = FD_HOLD_EN;
                    flush = DE_BUBBLE;
                    if (state == LUSTALL) begin
                        lu_nxt    = (lu_cnt == 3'd0) ? 3'd0 : lu_cnt - 3'd1;
                        state_nxt = (lu_cnt <= 3'd1) ? RUN : LUSTALL;
                    end else begin
                        lu_nxt    = LU_INIT;
                        state_nxt = (LU_INIT != 3'd0) ? LUSTALL : RUN;
                    end
                end else if (jumping && ihit) begin
                    flush  = FD_BUBBLE;
                    squash = 1'b1;
                end else if (!ihit) begin
                    en    = FD_HOLD_EN;
                    flush = DE_BUBBLE;
                end
            end
            MEMWAIT: begin
                if (!dhit) begin
                    en = '0;
                end else begin
                    state_nxt = (lu_cnt != 3'd0) ? LUSTALL : RUN;
                end
            end
            HALTED: begin
                en = '0;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign halted     = (state == HALTED);
    assign stall_inc  = !en[0] && (state != HALTED);
    assign dbg_state  = state;
    assign dbg_lu_cnt = lu_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CW'(1);
            if (squash && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two differently parameterised instances share
// stimulus and are compared each cycle against an event-level reference model.
module tb_hazard_ctrl_unit;

    logic clk, rst;
    logic ihit, dreq, dhit, halt, mispredict, jumping, load_use;

    logic [3:0] en_a, flush_a, stall_a, fcnt_a;
    logic       halted_a;
    logic [1:0] st_a;
    logic [2:0] lu_a;
    logic [5:0] en_b, flush_b;
    logic [7:0] stall_b, fcnt_b;
    logic       halted_b;
    logic [1:0] st_b;
    logic [2:0] lu_b;

    hazard_ctrl_unit #(.NLATCH(4), .BR_LATCH(2), .LU_BUBBLES(3), .CW(4)) u_a (
        .CLK(clk), .RST(rst), .ihit(ihit), .dreq(dreq), .dhit(dhit), .halt(halt),
        .mispredict(mispredict), .jumping(jumping), .load_use(load_use),
        .en(en_a), .flush(flush_a), .halted(halted_a), .stall_cnt(stall_a),
        .flush_cnt(fcnt_a), .dbg_state(st_a), .dbg_lu_cnt(lu_a)
    );

    hazard_ctrl_unit #(.NLATCH(6), .BR_LATCH(4), .LU_BUBBLES(1), .CW(8)) u_b (
        .CLK(clk), .RST(rst), .ihit(ihit), .dreq(dreq), .dhit(dhit), .halt(halt),
        .mispredict(mispredict), .jumping(jumping), .load_use(load_use),
        .en(en_b), .flush(flush_b), .halted(halted_b), .stall_cnt(stall_b),
        .flush_cnt(fcnt_b), .dbg_state(st_b), .dbg_lu_cnt(lu_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int p_n[2]  = '{4, 6};
    int p_br[2] = '{2, 4};
    int p_lu[2] = '{3, 1};
    int p_cw[2] = '{4, 8};

    // Abstract model state: halted flag, waiting-on-memory flag, bubbles still
    // owed to a load-use hazard, and the two event counters.
    int m_halted[2], m_wait[2], m_left[2], m_scnt[2], m_fcnt[2];
    int n_halted[2], n_wait[2], n_left[2], n_scnt[2], n_fcnt[2];

    logic [31:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_halted[k] = 0; m_wait[k] = 0; m_left[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_eval(input int k);
        logic [7:0] all1, e, f;
        int sq, cmax;
        all1 = 8'((1 << p_n[k]) - 1);
        cmax = (1 << p_cw[k]) - 1;
        e = all1; f = 8'd0; sq = 0;
        n_halted[k] = m_halted[k]; n_wait[k] = m_wait[k]; n_left[k] = m_left[k];
        if (m_halted[k] != 0) begin
            e = 8'd0;
        end else if (m_wait[k] != 0) begin
            if (!dhit) e = 8'd0;
            else n_wait[k] = 0;
        end else if (dreq && !dhit) begin
            e = 8'd0; n_wait[k] = 1;
        end else if (halt) begin
            f = all1 >> 1; n_halted[k] = 1;
        end else if (mispredict) begin
            f = 8'((1 << p_br[k]) - 1); n_left[k] = 0; sq = 1;
        end else if (m_left[k] > 0 || load_use) begin
            e = all1 & 8'hFE; f = 8'd2;
            n_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : p_lu[k] - 1;
        end else if (jumping && ihit) begin
            f = 8'd1; sq = 1;
        end else if (!ihit) begin
            e = all1 & 8'hFE; f = 8'd2;
        end
        n_scnt[k] = (!e[0] && m_halted[k] == 0 && m_scnt[k] < cmax) ? m_scnt[k] + 1 : m_scnt[k];
        n_fcnt[k] = (sq != 0 && m_fcnt[k] < cmax) ? m_fcnt[k] + 1 : m_fcnt[k];
        exp_q.push_back(32'(e));
        exp_q.push_back(32'(f));
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            m_halted[k] = n_halted[k]; m_wait[k] = n_wait[k]; m_left[k] = n_left[k];
            m_scnt[k] = n_scnt[k]; m_fcnt[k] = n_fcnt[k];
        end
    endtask

    function automatic int mode(input int k);
        if (m_halted[k] != 0) return 3;
        if (m_wait[k] != 0) return 1;
        if (m_left[k] > 0) return 2;
        return 0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic eval_and_check();
        model_eval(0);
        model_eval(1);
        check("en_a", 32'(en_a), exp_q.pop_front());
        check("flush_a", 32'(flush_a), exp_q.pop_front());
        check("en_b", 32'(en_b), exp_q.pop_front());
        check("flush_b", 32'(flush_b), exp_q.pop_front());
        check("halted_a", 32'(halted_a), 32'(m_halted[0]));
        check("halted_b", 32'(halted_b), 32'(m_halted[1]));
        check("stall_a", 32'(stall_a), 32'(m_scnt[0]));
        check("stall_b", 32'(stall_b), 32'(m_scnt[1]));
        check("fcnt_a", 32'(fcnt_a), 32'(m_fcnt[0]));
        check("fcnt_b", 32'(fcnt_b), 32'(m_fcnt[1]));
        check("lu_a", 32'(lu_a), 32'(m_left[0]));
        check("lu_b", 32'(lu_b), 32'(m_left[1]));
        check("state_a", 32'(st_a), 32'(mode(0)));
        check("state_b", 32'(st_b), 32'(mode(1)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic i_ihit, input logic i_dreq, input logic i_dhit,
                          input logic i_halt, input logic i_mp, input logic i_jmp,
                          input logic i_lu);
        ihit = i_ihit; dreq = i_dreq; dhit = i_dhit; halt = i_halt;
        mispredict = i_mp; jumping = i_jmp; load_use = i_lu;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next.
    task automatic drive(input logic i_ihit, input logic i_dreq, input logic i_dhit,
                         input logic i_halt, input logic i_mp, input logic i_jmp,
                         input logic i_lu);
        set_in(i_ihit, i_dreq, i_dhit, i_halt, i_mp, i_jmp, i_lu);
        @(negedge clk);
        eval_and_check();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, held across one rising edge.
    task automatic pulse_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_en_a", 32'(en_a), 32'hF);
        check("rst_flush_a", 32'(flush_a), 32'h0);
        check("rst_halted_a", 32'(halted_a), 32'h0);
        @(negedge clk);
        eval_and_check();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        eval_and_check();
        @(posedge clk);
        #1 rst = 1'b0;

        // Load-use burst: three bubble cycles on the LU_BUBBLES=3 instance.
        drive(1, 0, 0, 0, 0, 0, 1);
        check("lu1_en", 32'(en_a), 32'hE);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("lu2_flush", 32'(flush_a), 32'h2);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("lu_done_en", 32'(en_a), 32'hF);
        check("lu_stall_cnt", 32'(stall_a), 32'd3);

        // Reset while in the middle of a load-use stall.
        drive(1, 0, 0, 0, 0, 0, 1);
        pulse_reset();
        check("rst_stall", 32'(stall_a), 32'd0);

        // Data miss inside a load-use stall, then the remaining bubbles.
        drive(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0);
        pulse_reset();

        // Squash rules.
        drive(1, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("squash_fcnt", 32'(fcnt_a), 32'd2);

        // Memory wait beats a simultaneous mispredict; mispredict taken on dhit.
        drive(1, 1, 0, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);

        // Halt beats mispredict, then stays halted.
        drive(1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 100; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        check("halt_hold", 32'(halted_a), 32'd1);
        pulse_reset();

        // Stall counter saturation on the CW=4 instance.
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0);
        check("sat_stall", 32'(stall_a), 32'd15);
        pulse_reset();

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 2 ||
                (m_halted[0] != 0 && $urandom_range(0, 9) == 0)) begin
                pulse_reset();
            end else begin
                logic r_dreq;
                r_dreq = ($urandom_range(0, 99) < 20);
                drive($urandom_range(0, 99) < 80, r_dreq, $urandom_range(0, 99) < 40,
                      $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
                      $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
            end
        end

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
